// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard control for a 5-stage in-order pipeline. It picks the stall and
//   flush controls for PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. The sources it arbitrates are:
//     - a data-side wait
//     - an EX-stage redirect
//     - a load-use dependency
//     - an instruction-fetch wait
//   After a redirect taken while a fetch is still outstanding, the FSM enters
//   REDIR_WAIT. In that state the wrong-path fetch is discarded when it
//   completes.
//
//   Optional feature: define PIPE_HAZARD_PERF_EN to build three 32-bit
//   wrapping performance counters. When it is undefined, cnt_* are tied to 0.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_busy, d_busy             fetch / data access not complete this cycle
//   ex_is_load, ex_rd          EX instruction is a load, and its rd
//   id_rs1/2, id_use1/2        ID source registers and their read-enables
//   ex_redirect                taken branch/jump resolved in EX
//   stall_*                    hold PC or the named pipeline register
//   flush_*                    load a bubble; takes precedence over stall
//   redir_pend                 FSM is in REDIR_WAIT
//   cnt_dstall/luse/redir      performance counters
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_busy,
  input  logic        d_busy,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic        ex_redirect,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        stall_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        redir_pend,
  output logic [31:0] cnt_dstall,
  output logic [31:0] cnt_luse,
  output logic [31:0] cnt_redir
);

  typedef enum logic {RUN, REDIR_WAIT} state_t;

  state_t r_state;
  state_t w_next;
  logic   w_luse;
  logic   w_redir_act;

  assign w_luse = ex_is_load && (ex_rd != 5'd0) &&
                  ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

  // A redirect is honoured only when MEM is not holding EX.
  assign w_redir_act = ex_redirect && !d_busy;

  always_ff @(posedge clk) begin
    r_state <= w_next;
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    w_next      = r_state;
    if (reset) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      w_next      = RUN;
    end else begin
      if (d_busy) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        stall_memwb = 1'b1;
      end else if (ex_redirect) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (r_state == RUN && i_busy) w_next = REDIR_WAIT;
      end else if (w_luse) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (i_busy && r_state == RUN) begin
        stall_pc   = 1'b1;
        flush_ifid = 1'b1;
      end
      // The wrong-path fetch is still in flight. Keep PC and drop whatever
      // IF delivers, even while MEM is stalling the rest of the pipe.
      // A fresh redirect restarts the wait.
      if (r_state == REDIR_WAIT) begin
        stall_pc   = 1'b1;
        flush_ifid = 1'b1;
        if (!w_redir_act && !i_busy) w_next = RUN;
      end
    end
  end

  assign redir_pend = !reset && (r_state == REDIR_WAIT);

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] r_cnt_dstall;
  logic [31:0] r_cnt_luse;
  logic [31:0] r_cnt_redir;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_dstall <= 32'd0;
      r_cnt_luse   <= 32'd0;
      r_cnt_redir  <= 32'd0;
    end else begin
      if (d_busy)                                r_cnt_dstall <= r_cnt_dstall + 32'd1;
      if (!d_busy && !ex_redirect && w_luse)     r_cnt_luse   <= r_cnt_luse + 32'd1;
      if (w_redir_act)                           r_cnt_redir  <= r_cnt_redir + 32'd1;
    end
  end

  assign cnt_dstall = r_cnt_dstall;
  assign cnt_luse   = r_cnt_luse;
  assign cnt_redir  = r_cnt_redir;
`else
  assign cnt_dstall = 32'd0;
  assign cnt_luse   = 32'd0;
  assign cnt_redir  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl.
//   Each cycle, a reference model computes the expected outputs. Those values
//   go into a queue when the stimulus is applied. At the following negedge
//   the entry is popped and compared against the DUT.
//   The stimulus is a set of directed sequences followed by random traffic.
module tb_pipeline_hazard_ctrl;

  logic        clk, reset;
  logic        i_busy, d_busy, ex_is_load, id_use1, id_use2, ex_redirect;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, redir_pend;
  logic [31:0] cnt_dstall, cnt_luse, cnt_redir;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .i_busy(i_busy), .d_busy(d_busy),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .ex_redirect(ex_redirect),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .redir_pend(redir_pend),
    .cnt_dstall(cnt_dstall), .cnt_luse(cnt_luse), .cnt_redir(cnt_redir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Packed expected output vector:
  // {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
  //  flush_ifid, flush_idex, flush_exmem, redir_pend}
  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] dst, lu, rd;
  } exp_t;
  exp_t sb[$];

  // Reference model state.
  logic        m_wait;
  logic [31:0] m_dst, m_lu, m_rd;

  task automatic step(input logic rst, ib, db, ld, input logic [4:0] rd, r1, r2,
                      input logic u1, u2, rx);
    logic luse;
    logic [8:0] e;
    logic nwait;
    exp_t ent, got;
    reset = rst; i_busy = ib; d_busy = db; ex_is_load = ld; ex_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_use1 = u1; id_use2 = u2; ex_redirect = rx;
    luse = ld && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    nwait = m_wait;
    if (rst) begin
      e = 9'b00000_111_0;
      nwait = 1'b0;
    end else if (!m_wait) begin
      if (db)        e = 9'b11111_000_0;
      else if (rx) begin
        e = 9'b00000_110_0;
        nwait = ib;
      end
      else if (luse) e = 9'b11000_010_0;
      else if (ib)   e = 9'b10000_100_0;
      else           e = 9'b0;
    end else begin
      if (db)        e = 9'b11111_100_1;
      else if (rx)   e = 9'b10000_110_1;
      else if (luse) e = 9'b11000_110_1;
      else           e = 9'b10000_100_1;
      nwait = (rx && !db) || ib;
    end
    ent.ctl = e; ent.dst = m_dst; ent.lu = m_lu; ent.rd = m_rd;
    sb.push_back(ent);
    @(negedge clk);
    got = sb.pop_front();
    chk("ctl", {23'd0, stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                flush_ifid, flush_idex, flush_exmem, redir_pend}, {23'd0, got.ctl});
    chk("cnt_dstall", cnt_dstall, got.dst);
    chk("cnt_luse",   cnt_luse,   got.lu);
    chk("cnt_redir",  cnt_redir,  got.rd);
    m_wait = nwait;
`ifdef PIPE_HAZARD_PERF_EN
    if (rst) begin
      m_dst = 0; m_lu = 0; m_rd = 0;
    end else begin
      if (db) m_dst++;
      if (!db && !rx && luse) m_lu++;
      if (!db && rx) m_rd++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ib);
    step(0, ib, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_wait = 0; m_dst = 0; m_lu = 0; m_rd = 0;
    reset = 1; i_busy = 0; d_busy = 0; ex_is_load = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0; ex_redirect = 0;
    @(posedge clk); #1;
    // Reset state.
    step(1, 1, 1, 1, 5, 5, 5, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    // Load-use on rs1, then with rd=0, then on rs2, then rs2 unused.
    step(0, 0, 0, 1, 5, 5, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 7, 1, 7, 0, 1, 0);
    step(0, 0, 0, 1, 7, 1, 7, 1, 0, 0);
    idle(1);
    // Redirect and load-use in the same cycle, with the fetch complete.
    step(0, 0, 0, 1, 5, 5, 0, 1, 0, 1);
    idle(0);
    // Redirect while the fetch is outstanding for 3 cycles.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1); idle(1); idle(0); idle(0);
    // d_busy together with a redirect for 2 cycles, then the redirect lands.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // REDIR_WAIT entered, then d_busy and a further redirect inside it.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 3, 3, 0, 1, 0, 0);
    idle(0);
    // Reset asserted while in REDIR_WAIT.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    idle(0);
`ifdef PIPE_HAZARD_PERF_EN
    // Counter wrap from all-ones.
    dut.r_cnt_dstall = 32'hFFFF_FFFF;
    m_dst = 32'hFFFF_FFFF;
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("dstall_wrap", cnt_dstall, 32'd0);
`endif
    // Random traffic. Register numbers are kept small so that hazards occur.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
